// File: rtl/cpu_pkg.sv
// Shared CPU parameters and types for the register file and its helpers.
package cpu_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_wr_decoder.sv
// One-hot decoder for register-file write and issue selects; index 0 is the
// hardwired zero register and never gets a select.
module reg_wr_decoder
  import cpu_pkg::reg_addr_t;
#(
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] onehot
);

  // Raise the addressed bit when enabled, then mask off register 0.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
    onehot[0] = 1'b0;
  end

endmodule

// File: rtl/reg_file_wb.sv
// Two-read / one-write register file with write-first bypass and a
// per-register pending-write scoreboard for issue hazard detection.
module reg_file_wb
  import cpu_pkg::reg_addr_t;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [ADDR_W-1:0]      raddr1,
  input  logic [ADDR_W-1:0]      raddr2,
  output logic [DATA_W-1:0]      rdata1,
  output logic [DATA_W-1:0]      rdata2,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      issue_rd,
  output logic                   hazard1,
  output logic                   hazard2,
  output logic [2**ADDR_W-1:0]   busy
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0]  wr_sel;
  logic [NREGS-1:0]  iss_sel;
  logic [DATA_W-1:0] regs [NREGS];
  logic              match1;
  logic              match2;

  reg_wr_decoder #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NREGS)
  ) u_wr_dec (
    .en     (we),
    .addr   (waddr),
    .onehot (wr_sel)
  );

  reg_wr_decoder #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NREGS)
  ) u_iss_dec (
    .en     (issue_valid),
    .addr   (issue_rd),
    .onehot (iss_sel)
  );

  // Register array: clear on reset, otherwise load the write-selected entry; entry 0 stays zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      regs[0] <= '0;
      for (int i = 1; i < NREGS; i++) begin
        if (wr_sel[i]) begin
          regs[i] <= wdata;
        end
      end
    end
  end

  // Scoreboard: write-back clears, issue sets; set is applied last so the newer producer wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~wr_sel) | iss_sel;
    end
  end

  // Combinational reads with write-first bypass; index 0 always reads zero.
  always_comb begin
    match1 = we && (waddr == raddr1) && (raddr1 != '0);
    match2 = we && (waddr == raddr2) && (raddr2 != '0);
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) begin
      rdata1 = match1 ? wdata : regs[raddr1];
    end
    if (raddr2 != '0) begin
      rdata2 = match2 ? wdata : regs[raddr2];
    end
  end

  // A source is hazardous while reserved, unless its value is being written back right now.
  always_comb begin
    hazard1 = busy[raddr1] && !match1;
    hazard2 = busy[raddr2] && !match2;
  end

endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard testbench for reg_file_wb: directed vectors push expectations,
// a monitor pops and compares them on the falling edge.
module tb_reg_file_wb;
  import cpu_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                we;
  reg_addr_t           waddr;
  logic [DATA_W-1:0]   wdata;
  reg_addr_t           raddr1;
  reg_addr_t           raddr2;
  logic [DATA_W-1:0]   rdata1;
  logic [DATA_W-1:0]   rdata2;
  logic                issue_valid;
  reg_addr_t           issue_rd;
  logic                hazard1;
  logic                hazard2;
  logic [NUM_REGS-1:0] busy;

  typedef struct {
    string               name;
    logic [DATA_W-1:0]   r1;
    logic [DATA_W-1:0]   r2;
    logic                h1;
    logic                h2;
    logic [NUM_REGS-1:0] bsy;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   done        = 1'b0;

  reg_file_wb #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .we          (we),
    .waddr       (waddr),
    .wdata       (wdata),
    .raddr1      (raddr1),
    .raddr2      (raddr2),
    .rdata1      (rdata1),
    .rdata2      (rdata2),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .hazard1     (hazard1),
    .hazard2     (hazard2),
    .busy        (busy)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge and record the expected outputs.
  task automatic applyStimulus(
    input string name, input logic r, input logic w, input int wa,
    input logic [31:0] wd, input int ra1, input int ra2,
    input logic iv, input int ird, input logic chk,
    input logic [31:0] e_r1, input logic [31:0] e_r2,
    input logic e_h1, input logic e_h2, input logic [31:0] e_busy);
    exp_t e;
    @(posedge clk);
    #1;
    rst         = r;
    we          = w;
    waddr       = reg_addr_t'(wa);
    wdata       = wd;
    raddr1      = reg_addr_t'(ra1);
    raddr2      = reg_addr_t'(ra2);
    issue_valid = iv;
    issue_rd    = reg_addr_t'(ird);
    if (chk) begin
      e.name = name;
      e.r1   = e_r1;
      e.r2   = e_r2;
      e.h1   = e_h1;
      e.h2   = e_h2;
      e.bsy  = e_busy;
      sb.push_back(e);
    end
  endtask

  // Compare one popped expectation against the live DUT outputs.
  task automatic checkOutput(input exp_t e);
    vectors++;
    if (rdata1 !== e.r1) begin
      miscompares++;
      $display("[TB] FAIL %s rdata1: got %h expected %h", e.name, rdata1, e.r1);
    end
    if (rdata2 !== e.r2) begin
      miscompares++;
      $display("[TB] FAIL %s rdata2: got %h expected %h", e.name, rdata2, e.r2);
    end
    if (hazard1 !== e.h1) begin
      miscompares++;
      $display("[TB] FAIL %s hazard1: got %b expected %b", e.name, hazard1, e.h1);
    end
    if (hazard2 !== e.h2) begin
      miscompares++;
      $display("[TB] FAIL %s hazard2: got %b expected %b", e.name, hazard2, e.h2);
    end
    if (busy !== e.bsy) begin
      miscompares++;
      $display("[TB] FAIL %s busy: got %h expected %h", e.name, busy, e.bsy);
    end
  endtask

  // Monitor: on each falling edge, pop any pending expectation and compare.
  initial begin
    while (!done) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        checkOutput(sb.pop_front());
      end
    end
  end

  // Directed vectors; expected values are hand-derived from the register/scoreboard history.
  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    issue_valid = 1'b0; issue_rd = '0;
    //             name            rst we wa wdata         ra1 ra2 iv ird chk  r1            r2            h1 h2 busy
    applyStimulus("reset",         1, 0, 0, 32'h0,        5, 31, 0, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0);
    applyStimulus("reset_state",   0, 0, 0, 32'h0,        5, 31, 0, 0, 1, 32'h0,        32'h0,        0, 0, 32'h0);
    applyStimulus("write_r0",      0, 1, 0, 32'hDEADBEEF, 0, 0,  0, 0, 1, 32'h0,        32'h0,        0, 0, 32'h0);
    applyStimulus("r0_after",      0, 0, 0, 32'h0,        0, 5,  0, 0, 1, 32'h0,        32'h0,        0, 0, 32'h0);
    applyStimulus("issue7",        0, 0, 0, 32'h0,        7, 0,  1, 7, 1, 32'h0,        32'h0,        0, 0, 32'h0);
    applyStimulus("hazard7",       0, 0, 0, 32'h0,        7, 7,  0, 0, 1, 32'h0,        32'h0,        1, 1, 32'h80);
    applyStimulus("bypass7",       0, 1, 7, 32'h12345678, 7, 0,  0, 0, 1, 32'h12345678, 32'h0,        0, 0, 32'h80);
    applyStimulus("after7",        0, 0, 0, 32'h0,        7, 7,  0, 0, 1, 32'h12345678, 32'h12345678, 0, 0, 32'h0);
    applyStimulus("set_wins9",     0, 1, 9, 32'hA5A5A5A5, 9, 7,  1, 9, 1, 32'hA5A5A5A5, 32'h12345678, 0, 0, 32'h0);
    applyStimulus("after9",        0, 0, 0, 32'h0,        9, 0,  0, 0, 1, 32'hA5A5A5A5, 32'h0,        1, 0, 32'h200);
    applyStimulus("issue6",        0, 0, 0, 32'h0,        6, 9,  1, 6, 1, 32'h0,        32'hA5A5A5A5, 0, 1, 32'h200);
    applyStimulus("set2_clr6",     0, 1, 6, 32'h66,       6, 2,  1, 2, 1, 32'h66,       32'h0,        0, 0, 32'h240);
    applyStimulus("after_2_6",     0, 0, 0, 32'h0,        2, 6,  0, 0, 1, 32'h0,        32'h66,       1, 0, 32'h204);
    applyStimulus("write_nonbusy", 0, 1, 3, 32'h33,       3, 9,  0, 0, 1, 32'h33,       32'hA5A5A5A5, 0, 1, 32'h204);
    applyStimulus("reissue2",      0, 0, 0, 32'h0,        3, 2,  1, 2, 1, 32'h33,       32'h0,        0, 1, 32'h204);
    applyStimulus("clear2",        0, 1, 2, 32'h22,       2, 0,  0, 0, 1, 32'h22,       32'h0,        0, 0, 32'h204);
    applyStimulus("issue3",        0, 0, 0, 32'h0,        2, 3,  1, 3, 1, 32'h22,       32'h33,       0, 0, 32'h200);
    applyStimulus("issue4",        0, 0, 0, 32'h0,        3, 4,  1, 4, 1, 32'h33,       32'h0,        1, 0, 32'h208);
    applyStimulus("rst_override",  1, 1, 3, 32'hFFFFFFFF, 3, 4,  1, 5, 1, 32'hFFFFFFFF, 32'h0,        0, 1, 32'h218);
    applyStimulus("post_rst",      0, 0, 0, 32'h0,        3, 9,  0, 0, 1, 32'h0,        32'h0,        0, 0, 32'h0);
    applyStimulus("issue_r0",      0, 0, 0, 32'h0,        0, 7,  1, 0, 1, 32'h0,        32'h0,        0, 0, 32'h0);
    applyStimulus("r0_not_busy",   0, 0, 0, 32'h0,        0, 0,  0, 0, 1, 32'h0,        32'h0,        0, 0, 32'h0);

    // Give the monitor a bounded number of cycles to drain the queue.
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(posedge clk);
    end
    if (sb.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_file_wb.md
REG_FILE_WB -- requirements
Module: reg_file_wb

Interface
REQ-001 Parameter DATA_W, default 32, register and data-bus width.
REQ-002 Parameter ADDR_W, default 5, register address width; NUM_REGS = 2**ADDR_W.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 we  input  1  write-back enable.
REQ-006 waddr  input  ADDR_W  write-back destination register index.
REQ-007 wdata  input  DATA_W  write-back data.
REQ-008 raddr1  input  ADDR_W  read port 1 index.
REQ-009 raddr2  input  ADDR_W  read port 2 index.
REQ-010 rdata1  output  DATA_W  read port 1 data, combinational.
REQ-011 rdata2  output  DATA_W  read port 2 data, combinational.
REQ-012 issue_valid  input  1  an instruction issues this cycle and reserves issue_rd.
REQ-013 issue_rd  input  ADDR_W  destination register of the issuing instruction.
REQ-014 hazard1  output  1  read port 1 source is pending; data not yet valid.
REQ-015 hazard2  output  1  read port 2 source is pending; data not yet valid.
REQ-016 busy  output  NUM_REGS  per-register pending-write scoreboard; bit i set means register i is reserved.

Function
REQ-017 Write path SHALL one-hot-decode waddr; on the clock edge with we=1 and waddr!=0, regs[waddr] <= wdata; all other registers hold.
REQ-018 Register 0 SHALL read as 0 always; writes and issues targeting index 0 SHALL be ignored; busy[0] SHALL stay 0.
REQ-019 Reads SHALL be combinational from the register array, zero-cycle latency.
REQ-020 Write-first bypass: when we=1, waddr==raddrN, and raddrN!=0, rdataN SHALL equal wdata in the same cycle.
REQ-021 Scoreboard set: on the edge with issue_valid=1 and issue_rd!=0, busy[issue_rd] <= 1.
REQ-022 Scoreboard clear: on the edge with we=1 and waddr!=0, busy[waddr] <= 0.
REQ-023 Simultaneous set and clear of the same index SHALL leave busy=1: set wins, because the newer producer owns the register.
REQ-024 Set and clear of different indices in the same cycle SHALL both take effect.
REQ-025 hazardN SHALL equal busy[raddrN] AND NOT (we AND waddr==raddrN); it is 0 when raddrN==0.
REQ-026 A write to a non-busy register SHALL be legal: data is updated, busy is unchanged, and no error is flagged.
REQ-027 Repeated issue to an already busy register SHALL keep busy=1 with no count; the first matching write clears it.

Reset
REQ-028 With rst=1 at an edge, all registers SHALL become 0 and busy SHALL become all 0.
REQ-029 rst SHALL override we and issue_valid in the same cycle; no write and no reservation takes effect.
REQ-030 After reset, rdata1=rdata2=0 and hazard1=hazard2=0 until the first write or issue.
REQ-031 Reset asserted mid-operation SHALL discard all pending reservations; no write-back is replayed.

Structure
REQ-032 Shared package cpu_pkg SHALL hold DATA_W, ADDR_W, NUM_REGS, and typedef reg_addr_t (logic [ADDR_W-1:0]); the block SHALL import it.
REQ-033 The write-enable decode SHALL be a sub-module reg_wr_decoder: inputs en and addr, output a NUM_REGS one-hot vector, bit 0 forced to 0.
REQ-034 The register array and scoreboard SHALL be flops with synchronous reset; no latches; reads SHALL not be registered.

Verification
REQ-035 rst=1 for 1 cycle, then raddr1=5, raddr2=31 -> rdata1=0, rdata2=0, busy=0, hazard1=hazard2=0.
REQ-036 we=1, waddr=0, wdata=0xDEADBEEF, then raddr1=0 -> rdata1=0; busy[0]=0.
REQ-037 issue_valid=1, issue_rd=7; next cycle raddr1=7 -> hazard1=1. Then we=1, waddr=7, wdata=0x12345678 -> same cycle rdata1=0x12345678, hazard1=0; next cycle busy[7]=0 and rdata1=0x12345678.
REQ-038 Same cycle: issue_valid=1, issue_rd=9, we=1, waddr=9, wdata=0xA5A5A5A5 -> next cycle regs[9]=0xA5A5A5A5 and busy[9]=1.
REQ-039 busy[3]=1 and busy[4]=1; rst=1 together with we=1, waddr=3, wdata=0xFFFFFFFF -> next cycle busy=0 and rdata at index 3 = 0.
REQ-040 Same cycle: issue_valid=1, issue_rd=2, we=1, waddr=6 -> busy[2]=1 and busy[6]=0 after the edge.
